// File: rtl/vending_pkg.sv
// vending_pkg: coin codes, controller states and coin decode helpers for vending_ctrl_param.
// The REFUND state only exists when VEND_CANCEL_EN is defined.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'b00,
    ST_DISP    = 2'b01,
    ST_CHANGE  = 2'b10
`ifdef VEND_CANCEL_EN
    , ST_REFUND = 2'b11
`endif
  } state_e;

  // Coin value in 5-units; the third denomination is configurable.
  function automatic logic [7:0] coin_units(input logic [1:0] code, input logic [7:0] coin3);
    logic [7:0] v;
    case (code)
      COIN_5:  v = 8'd1;
      COIN_10: v = 8'd2;
      COIN_3:  v = coin3;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  function automatic logic coin_valid(input logic [1:0] code, input logic [7:0] coin3);
    return (code != COIN_3) || (coin3 != 8'd0);
  endfunction

endpackage

// File: rtl/vend_payout.sv
// vend_payout: loadable down-counter holding the number of 5-unit coins still to pay out.
// done flags the final pulse of a burst, empty flags a zero count.
module vend_payout
  import vending_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             active,
  output logic             done,
  output logic             empty
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = cnt_in;
    end else if (active && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done  = (cnt_q == CNT_W'(1));
  assign empty = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/vending_ctrl_param.sv
// vending_ctrl_param: parametrised coin-accumulating vending controller with change payout.
// Define VEND_CANCEL_EN to add the cancel port and the REFUND path.
module vending_ctrl_param
  import vending_pkg::*;
#(
  parameter int unsigned PRICE_UNITS = 4,
  parameter int unsigned COIN3_UNITS = 0,
  parameter int unsigned CREDIT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          coin,
`ifdef VEND_CANCEL_EN
  input  logic                cancel,
`endif
  output logic                dispense,
  output logic                chg5,
  output logic                busy,
  output logic                coin_rej,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_UNITS);
  localparam logic [7:0]          COIN3_C = 8'(COIN3_UNITS);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_q, dispense_d;
  logic                chg5_q, chg5_d;
  logic                busy_q, busy_d;
  logic                coin_rej_q, coin_rej_d;

  logic [7:0]          coin_u8_s;
  logic [CREDIT_W-1:0] coin_v_s;
  logic [CREDIT_W-1:0] total_s;
  logic                coin_ok_s;
  logic                rej_s;
  logic                pay_load_s;
  logic [CREDIT_W-1:0] pay_cnt_s;
  logic                pay_active_s;
  logic                pay_done_s;
  logic                pay_empty_s;

  vend_payout #(.CNT_W(CREDIT_W)) u_payout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (pay_load_s),
    .cnt_in (pay_cnt_s),
    .active (pay_active_s),
    .done   (pay_done_s),
    .empty  (pay_empty_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_COLLECT;
      credit_q   <= {CREDIT_W{1'b0}};
      dispense_q <= 1'b0;
      chg5_q     <= 1'b0;
      busy_q     <= 1'b0;
      coin_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      chg5_q     <= chg5_d;
      busy_q     <= busy_d;
      coin_rej_q <= coin_rej_d;
    end
  end

  always_comb begin
    coin_u8_s    = coin_units(coin, COIN3_C);
    coin_v_s     = CREDIT_W'(coin_u8_s);
    coin_ok_s    = coin_valid(coin, COIN3_C);
    total_s      = credit_q + coin_v_s;
    state_d      = state_q;
    credit_d     = credit_q;
    rej_s        = 1'b0;
    pay_load_s   = 1'b0;
    pay_cnt_s    = {CREDIT_W{1'b0}};
    pay_active_s = 1'b0;
    case (state_q)
      ST_COLLECT: begin
`ifdef VEND_CANCEL_EN
        // Cancel with credit outranks any coin presented in the same cycle.
        if (cancel && (credit_q != {CREDIT_W{1'b0}})) begin
          state_d    = ST_REFUND;
          pay_load_s = 1'b1;
          pay_cnt_s  = credit_q;
          credit_d   = {CREDIT_W{1'b0}};
          rej_s      = (coin != COIN_NONE);
        end else
`endif
        if (coin == COIN_NONE) begin
          credit_d = credit_q;
        end else if (!coin_ok_s) begin
          rej_s = 1'b1;
        end else if (total_s >= PRICE_C) begin
          state_d    = ST_DISP;
          credit_d   = {CREDIT_W{1'b0}};
          pay_load_s = 1'b1;
          pay_cnt_s  = total_s - PRICE_C;
        end else begin
          credit_d = total_s;
        end
      end
      ST_DISP: begin
        rej_s   = (coin != COIN_NONE);
        state_d = pay_empty_s ? ST_COLLECT : ST_CHANGE;
      end
`ifdef VEND_CANCEL_EN
      ST_CHANGE, ST_REFUND: begin
`else
      ST_CHANGE: begin
`endif
        rej_s        = (coin != COIN_NONE);
        pay_active_s = 1'b1;
        if (pay_done_s || pay_empty_s) begin
          state_d = ST_COLLECT;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = ST_COLLECT;
        credit_d = {CREDIT_W{1'b0}};
      end
    endcase
  end

  // Outputs are registered copies of the next-state decode, so they track state_q exactly.
  always_comb begin
    dispense_d = (state_d == ST_DISP);
`ifdef VEND_CANCEL_EN
    chg5_d     = (state_d == ST_CHANGE) || (state_d == ST_REFUND);
`else
    chg5_d     = (state_d == ST_CHANGE);
`endif
    busy_d     = (state_d != ST_COLLECT);
    coin_rej_d = rej_s;
  end

  assign dispense = dispense_q;
  assign chg5     = chg5_q;
  assign busy     = busy_q;
  assign coin_rej = coin_rej_q;
  assign credit   = credit_q;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Table-driven scoreboard bench for vending_ctrl_param: one default instance and one with COIN3_UNITS=5.
module tb_vending_ctrl_param;

  localparam int unsigned PRICE_U  = 4;
  localparam int unsigned CREDIT_U = 4;
  localparam int unsigned COIN3_B  = 5;

  if ((PRICE_U - 1 + 2) >= (1 << CREDIT_U) || (PRICE_U - 1 + COIN3_B) >= (1 << CREDIT_U)) begin : g_bad_cfg
    initial $fatal(1, "FAIL cfg_rule CREDIT_W too narrow for price and coins");
  end

  typedef struct packed {
    logic       sel;      // 0 = default DUT, 1 = COIN3_UNITS=5 DUT
    logic       rst_n;
    logic [1:0] coin;
    logic       cancel;
    logic       dispense;
    logic       chg5;
    logic       busy;
    logic       coin_rej;
    logic [3:0] credit;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] coin_a, coin_b;
  logic       cancel_a;
  logic       disp_a, chg_a, busy_a, rej_a;
  logic       disp_b, chg_b, busy_b, rej_b;
  logic [3:0] cred_a, cred_b;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vending_ctrl_param #(.PRICE_UNITS(PRICE_U), .COIN3_UNITS(0), .CREDIT_W(CREDIT_U)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .coin(coin_a),
`ifdef VEND_CANCEL_EN
    .cancel(cancel_a),
`endif
    .dispense(disp_a), .chg5(chg_a), .busy(busy_a), .coin_rej(rej_a), .credit(cred_a)
  );

  vending_ctrl_param #(.PRICE_UNITS(PRICE_U), .COIN3_UNITS(COIN3_B), .CREDIT_W(CREDIT_U)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .coin(coin_b),
`ifdef VEND_CANCEL_EN
    .cancel(1'b0),
`endif
    .dispense(disp_b), .chg5(chg_b), .busy(busy_b), .coin_rej(rej_b), .credit(cred_b)
  );

  function automatic void add(input logic sel, input logic r, input logic [1:0] c, input logic can,
                              input logic d, input logic ch, input logic b, input logic rj,
                              input logic [3:0] cr);
    vec_t v;
    v.sel = sel; v.rst_n = r; v.coin = c; v.cancel = can;
    v.dispense = d; v.chg5 = ch; v.busy = b; v.coin_rej = rj; v.credit = cr;
    vecs.push_back(v);
  endfunction

  // Watchdog: bounds the whole run and flags an expired wait.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: vector run did not complete within the wait limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vec_t v, e;
    logic [7:0] act, want;
    logic [15:0] rst_act;
    rst_n = 1'b0; coin_a = 2'b00; coin_b = 2'b00; cancel_a = 1'b0;

    @(posedge clk);
    #1;
    rst_act = {disp_a, chg_a, busy_a, rej_a, cred_a, disp_b, chg_b, busy_b, rej_b, cred_b};
    checks++;
    if (rst_act !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state outputs after reset: got %b expected all zero", rst_act);
    end

    //   sel   rst   coin   can   disp  chg5  busy  rej   credit
    add(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);  // reset
    add(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);  // 10,10 exact
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);  // 5,5,idle,5,5
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);  // 10,5,10 -> 1 change
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);  // invalid coin 11
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);  // coins while busy
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);  // coin3=5: 10,25 -> 3 change
    add(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);  // reset during 2nd chg5
    add(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    add(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);  // single 25 from empty
    add(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
`ifdef VEND_CANCEL_EN
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);  // 5,10, cancel+5 -> refund 3
    add(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    add(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);  // cancel with no credit
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst_n    = v.rst_n;
      coin_a   = v.sel ? 2'b00 : v.coin;
      coin_b   = v.sel ? v.coin : 2'b00;
      cancel_a = v.sel ? 1'b0 : v.cancel;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      act  = e.sel ? {disp_b, chg_b, busy_b, rej_b, cred_b} : {disp_a, chg_a, busy_a, rej_a, cred_a};
      want = {e.dispense, e.chg5, e.busy, e.coin_rej, e.credit};
      checks++;
      if (act !== want) begin
        failures++;
        $display("FAIL vec%0d dut%0d {disp,chg5,busy,rej,credit}: got %b_%0d expected %b_%0d",
                 i, e.sel, act[7:4], act[3:0], want[7:4], want[3:0]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
